// File: rtl/uart_tx_ser.sv
// UART-16550 transmit serialiser: one-entry THR feeding a start/data/parity/stop
// shifter paced by the shared 16x oversampling enable.
module uart_tx_ser (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick16,
   input  logic [7:0] lcr,
   input  logic [7:0] thr_din,
   input  logic       thr_wr,
   output logic       stx,
   output logic       thre,
   output logic       temt,
   output logic       tx_busy
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] thr_q, thr_d;
   logic [7:0] shift_q, shift_d;
   logic [5:0] cfg_q, cfg_d;
   logic [4:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic       thre_q, thre_d;
   logic       stx_q, stx_d;
   logic       temt_q, temt_d;

   logic [2:0] last_idx;
   logic [4:0] stop_last;
   logic [7:0] data_mask;
   logic       data_xor;
   logic       par_bit;
   logic       bit_end;
   logic       load;
   logic       line_bit;
   logic       unused_lcr;

   assign unused_lcr = lcr[7];

   // Frame-derived constants come from the configuration captured at load.
   always_comb begin
      last_idx = {1'b0, cfg_q[1:0]} + 3'd4;
      unique case (cfg_q[1:0])
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      data_xor = ^(shift_q & data_mask);
      if (cfg_q[5]) begin
         par_bit = ~cfg_q[4];
      end else begin
         par_bit = cfg_q[4] ? data_xor : ~data_xor;
      end
      if (!cfg_q[2]) begin
         stop_last = 5'd15;
      end else if (cfg_q[1:0] == 2'b00) begin
         stop_last = 5'd23;
      end else begin
         stop_last = 5'd31;
      end
      bit_end = tick16 && (cnt_q[3:0] == 4'd15);
   end

   always_comb begin
      state_d = state_q;
      thr_d   = thr_q;
      shift_d = shift_q;
      cfg_d   = cfg_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      thre_d  = thre_q;
      load    = 1'b0;

      if (thr_wr && thre_q) begin
         thr_d  = thr_din;
         thre_d = 1'b0;
      end

      if (tick16 && (state_q != StIdle)) begin
         cnt_d = cnt_q + 5'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (!thre_q) begin
               load = 1'b1;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               idx_d   = 3'd0;
               cnt_d   = 5'd0;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = 5'd0;
               if (idx_q == last_idx) begin
                  state_d = cfg_q[3] ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               cnt_d   = 5'd0;
            end
         end
         StStop: begin
            if (tick16 && (cnt_q == stop_last)) begin
               cnt_d = 5'd0;
               if (!thre_q) begin
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Load overrides the tick increment, so a tick on the load edge is not counted.
      if (load) begin
         shift_d = thr_q;
         cfg_d   = lcr[5:0];
         thre_d  = 1'b1;
         state_d = StStart;
         cnt_d   = 5'd0;
         idx_d   = 3'd0;
      end

      unique case (state_d)
         StStart:  line_bit = 1'b0;
         StData:   line_bit = shift_d[idx_d];
         StParity: line_bit = par_bit;
         default:  line_bit = 1'b1;
      endcase

      stx_d  = lcr[6] ? 1'b0 : line_bit;
      temt_d = thre_d && (state_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         thr_q   <= 8'h00;
         shift_q <= 8'h00;
         cfg_q   <= 6'h00;
         cnt_q   <= 5'd0;
         idx_q   <= 3'd0;
         thre_q  <= 1'b1;
         stx_q   <= 1'b1;
         temt_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         thr_q   <= thr_d;
         shift_q <= shift_d;
         cfg_q   <= cfg_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         thre_q  <= thre_d;
         stx_q   <= stx_d;
         temt_q  <= temt_d;
      end
   end

   assign stx     = stx_q;
   assign thre    = thre_q;
   assign temt    = temt_q;
   assign tx_busy = (state_q != StIdle);

endmodule
